// File: rtl/wireless_rx_pkg.sv
// Shared types and defaults for the wireless serial receiver.
// Holds the FSM state enum, default link constants and the counter-width helper.
package wireless_rx_pkg;

    localparam int DEF_CLK_HZ     = 50_000_000;
    localparam int DEF_BAUD       = 9600;
    localparam int DEF_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    // Bits needed to hold a counter running 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wireless_rx_fifo.sv
// Received-byte FIFO: head, count and full/empty are registered and update one cycle after push/pop.
// A push when full is refused unless a pop happens in the same cycle; a pop when empty is ignored.
module wireless_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic [W-1:0]                 push_dat,
    input  logic                         pop,
    output logic [W-1:0]                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt;
    logic [CW-1:0] cnt_nxt;
    logic [W-1:0]  head_nxt;
    logic          do_push, do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        rd_nxt   = do_pop ? rd_ptr + AW'(1) : rd_ptr;
        cnt_nxt  = count + CW'(do_push) - CW'(do_pop);
        // The byte being pushed becomes head when nothing older survives this cycle.
        if (cnt_nxt == '0)
            head_nxt = '0;
        else if (do_pop ? (count == CW'(1)) : empty)
            head_nxt = push_dat;
        else
            head_nxt = mem[rd_nxt];
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            rd_ptr <= rd_nxt;
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            count <= cnt_nxt;
            head  <= head_nxt;
        end
    end

endmodule

// File: rtl/wireless_rx_deserializer.sv
// Oversampling 8N1 UART receiver feeding a byte FIFO; outputs update one cycle after a push or pop edge.
// No backpressure on the line: a byte arriving into a full FIFO is dropped and flagged; RX_PARITY_EN adds even parity.
module wireless_rx_deserializer
    import wireless_rx_pkg::*;
#(
    parameter int CLK_HZ     = DEF_CLK_HZ,
    parameter int BAUD       = DEF_BAUD,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              rx_serial,
    input  logic                              pop,
    input  logic                              err_clr,
    output logic [7:0]                        data_out,
    output logic                              data_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              overrun,
    output logic                              frame_err,
    output logic                              parity_err
);
    localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int TW  = cnt_width(DIV);
    localparam int SW  = cnt_width(OVERSAMPLE);

    logic          rx_meta, rxs;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    rx_state_t     state, state_nxt;
    logic [SW-1:0] samp_cnt, samp_nxt;
    logic [2:0]    bit_cnt, bit_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          par_bad, par_bad_nxt;
    logic          byte_vld, frame_evt, pop_q, pop_evt, fifo_full, fifo_empty, overrun_evt;
`ifdef RX_PARITY_EN
    logic          par_evt;
`endif

    assign tick    = (tick_cnt == TW'(DIV-1));
    assign pop_evt = pop && !pop_q;

    always_comb begin
        state_nxt   = state;
        samp_nxt    = samp_cnt;
        bit_nxt     = bit_cnt;
        shift_nxt   = shift;
        par_bad_nxt = par_bad;
        byte_vld    = 1'b0;
        frame_evt   = 1'b0;
`ifdef RX_PARITY_EN
        par_evt     = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                samp_nxt    = '0;
                bit_nxt     = '0;
                par_bad_nxt = 1'b0;
                if (!rxs)
                    state_nxt = ST_START;
            end
            ST_START: if (tick) begin
                if (samp_cnt == SW'(OVERSAMPLE/2-1)) begin
                    samp_nxt  = '0;
                    state_nxt = rxs ? ST_IDLE : ST_DATA;
                end else
                    samp_nxt = samp_cnt + SW'(1);
            end
            ST_DATA: if (tick) begin
                if (samp_cnt == SW'(OVERSAMPLE-1)) begin
                    samp_nxt  = '0;
                    shift_nxt = {rxs, shift[7:1]};
                    bit_nxt   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
`ifdef RX_PARITY_EN
                        state_nxt = ST_PARITY;
`else
                        state_nxt = ST_STOP;
`endif
                end else
                    samp_nxt = samp_cnt + SW'(1);
            end
`ifdef RX_PARITY_EN
            ST_PARITY: if (tick) begin
                if (samp_cnt == SW'(OVERSAMPLE-1)) begin
                    samp_nxt  = '0;
                    state_nxt = ST_STOP;
                    if (rxs != ^shift) begin
                        par_evt     = 1'b1;
                        par_bad_nxt = 1'b1;
                    end
                end else
                    samp_nxt = samp_cnt + SW'(1);
            end
`endif
            ST_STOP: if (tick) begin
                if (samp_cnt == SW'(OVERSAMPLE-1)) begin
                    // Leave in the same cycle so a back-to-back start bit is not missed.
                    state_nxt = ST_IDLE;
                    if (!rxs)
                        frame_evt = 1'b1;
                    else if (!par_bad)
                        byte_vld = 1'b1;
                end else
                    samp_nxt = samp_cnt + SW'(1);
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign overrun_evt = byte_vld && fifo_full && !pop_evt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta   <= 1'b1;
            rxs       <= 1'b1;
            tick_cnt  <= '0;
            state     <= ST_IDLE;
            samp_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            par_bad   <= 1'b0;
            pop_q     <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_meta   <= rx_serial;
            rxs       <= rx_meta;
            // Realign the bit timing to the falling edge of each start bit.
            if (state == ST_IDLE && state_nxt == ST_START)
                tick_cnt <= '0;
            else if (tick)
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + TW'(1);
            state     <= state_nxt;
            samp_cnt  <= samp_nxt;
            bit_cnt   <= bit_nxt;
            shift     <= shift_nxt;
            par_bad   <= par_bad_nxt;
            pop_q     <= pop;
            overrun   <= (overrun && !err_clr) || overrun_evt;
            frame_err <= (frame_err && !err_clr) || frame_evt;
        end
    end

`ifdef RX_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            parity_err <= 1'b0;
        else
            parity_err <= (parity_err && !err_clr) || par_evt;
    end
`else
    assign parity_err = 1'b0;
`endif

    wireless_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (byte_vld),
        .push_dat (shift),
        .pop      (pop_evt),
        .head     (data_out),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign data_valid = !fifo_empty;

endmodule

// File: tb/tb_wireless_rx_deserializer.sv
// Directed bench for wireless_rx_deserializer; bytes expected at each pop edge are queued by stimulus and checked by a monitor.
`timescale 1ns/1ps
module tb_wireless_rx_deserializer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_serial = 1'b1;
    logic       pop = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic [2:0] fifo_count;
    logic       overrun, frame_err, parity_err;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    bit         pop_seen = 1'b0;

`ifdef RX_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam int STOP_C     = 1682;
    logic          par_flip   = 1'b0;
`else
    localparam int FRAME_BITS = 10;
    localparam int STOP_C     = 1522;
`endif

    always #5 clk = ~clk;

    wireless_rx_deserializer #(
        .CLK_HZ     (1_600_000),
        .BAUD       (10_000),
        .OVERSAMPLE (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_serial  (rx_serial),
        .pop        (pop),
        .err_clr    (err_clr),
        .data_out   (data_out),
        .data_valid (data_valid),
        .fifo_count (fifo_count),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: each rising pop must find the queued byte at the head.
    always @(negedge clk) begin
        if (!reset_n)
            pop_seen = 1'b0;
        else begin
            if (pop && !pop_seen) begin
                if (exp_q.size() > 0)
                    check("pop_data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
                else
                    check("pop_when_empty_valid", {31'd0, data_valid}, 32'd0);
            end
            pop_seen = pop;
        end
    end

    // One frame, 160 clk per bit; err_clr/pop can be aligned to the stop-centre sample cycle.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int clr_at,
                              input int pop_at, input bit chk_push);
        logic [FRAME_BITS-1:0] bits;
`ifdef RX_PARITY_EN
        bits = {stop_bit, (^b) ^ par_flip, b, 1'b0};
`else
        bits = {stop_bit, b, 1'b0};
`endif
        for (int c = 0; c < FRAME_BITS*160; c++) begin
            @(posedge clk); #1;
            rx_serial = bits[c/160];
            err_clr   = (c == clr_at);
            if (pop_at >= 0)
                pop = (c >= pop_at) && (c < pop_at + 4);
            if (chk_push && c == STOP_C)
                check("valid_before_push", {31'd0, data_valid}, 32'd0);
            if (chk_push && c == STOP_C + 1)
                check("valid_cycle_after_push", {31'd0, data_valid}, 32'd1);
        end
        rx_serial = 1'b1;
        err_clr   = 1'b0;
        pop       = 1'b0;
        repeat (40) @(posedge clk);
        #1;
    endtask

    task automatic do_pop();
        @(posedge clk); #1 pop = 1'b1;
        repeat (3) @(posedge clk);
        #1 pop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_data_out"},   {24'd0, data_out},   32'd0);
        check({tag, "_data_valid"}, {31'd0, data_valid}, 32'd0);
        check({tag, "_fifo_count"}, {29'd0, fifo_count}, 32'd0);
        check({tag, "_overrun"},    {31'd0, overrun},    32'd0);
        check({tag, "_frame_err"},  {31'd0, frame_err},  32'd0);
        check({tag, "_parity_err"}, {31'd0, parity_err}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (5) @(posedge clk);
        #1 check_idle_outputs("reset");
        reset_n = 1'b1;
        repeat (10) @(posedge clk);

        // 1: single good frame
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, -1, -1, 1'b1);
        check("t1_count", {29'd0, fifo_count}, 32'd1);
        check("t1_data",  {24'd0, data_out},   32'hA5);
        check("t1_flags", {29'd0, overrun, frame_err, parity_err}, 32'd0);
        do_pop();
        check("t1_empty_data", {24'd0, data_out}, 32'd0);

        // 2: short glitch on the line is rejected
        @(posedge clk); #1 rx_serial = 1'b0;
        repeat (40) @(posedge clk);
        #1 rx_serial = 1'b1;
        repeat (200) @(posedge clk);
        #1 check_idle_outputs("t2");

        // 3: overflow by one byte, then drain
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, -1, -1, 1'b0);
        end
        check("t3_count",   {29'd0, fifo_count}, 32'd4);
        check("t3_head",    {24'd0, data_out},   32'h01);
        check("t3_overrun", {31'd0, overrun},    32'd1);
        for (int i = 0; i < 5; i++) do_pop();
        check("t3_valid_after_drain", {31'd0, data_valid}, 32'd0);
        check("t3_data_after_drain",  {24'd0, data_out},   32'd0);
        check("t3_count_after_drain", {29'd0, fifo_count}, 32'd0);
        pulse_clr();
        check("t3_overrun_cleared", {31'd0, overrun}, 32'd0);

        // 4: framing error, clear, and clear colliding with a new error
        send_frame(8'h3C, 1'b0, -1, -1, 1'b0);
        check("t4_frame_err", {31'd0, frame_err},  32'd1);
        check("t4_count",     {29'd0, fifo_count}, 32'd0);
        pulse_clr();
        check("t4_frame_err_cleared", {31'd0, frame_err}, 32'd0);
        send_frame(8'h3C, 1'b0, STOP_C, -1, 1'b0);
        check("t4_err_beats_clear", {31'd0, frame_err}, 32'd1);
        pulse_clr();

        // 5: push into a full FIFO in the same cycle as a pop edge
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(8'(i * 16));
            send_frame(8'(i * 16), 1'b1, -1, -1, 1'b0);
        end
        check("t5_full_count", {29'd0, fifo_count}, 32'd4);
        exp_q.push_back(8'h77);
        send_frame(8'h77, 1'b1, -1, STOP_C, 1'b0);
        check("t5_count",   {29'd0, fifo_count}, 32'd4);
        check("t5_overrun", {31'd0, overrun},    32'd0);
        for (int i = 0; i < 4; i++) do_pop();
        check("t5_drained", {29'd0, fifo_count}, 32'd0);

        // 6: reset in the middle of a frame with a byte already buffered
        send_frame(8'h11, 1'b1, -1, -1, 1'b0);
        for (int c = 0; c < 500; c++) begin
            @(posedge clk); #1;
            rx_serial = (c < 160) ? 1'b0 : ((c / 160) % 2 == 1);
        end
        reset_n = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 check_idle_outputs("t6_in_reset");
        rx_serial = 1'b1;
        reset_n   = 1'b1;
        repeat (200) @(posedge clk);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, -1, -1, 1'b1);
        check("t6_data",  {24'd0, data_out},   32'h5A);
        check("t6_count", {29'd0, fifo_count}, 32'd1);
        do_pop();

`ifdef RX_PARITY_EN
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1, -1, -1, 1'b0);
        par_flip = 1'b0;
        check("par_err",   {31'd0, parity_err}, 32'd1);
        check("par_count", {29'd0, fifo_count}, 32'd0);
        pulse_clr();
        check("par_err_cleared", {31'd0, parity_err}, 32'd0);
`endif

        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
